// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator with sync, blanking, pixel-prefetch
//                requests and graceful end-of-frame stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACT    = 640,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACT    = 480,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PREFETCH = 2,
    parameter int CW       = 11
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_blank_n,
    output logic          o_sync_n,
    output logic          o_vga_clk,
    output logic          o_req,
    output logic [CW-1:0] o_req_x,
    output logic [CW-1:0] o_req_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_busy,
    output logic [15:0]   o_frame_cnt
);

    localparam int c_H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int c_H_TOTAL = c_H_BLANK + H_ACT;
    localparam int c_V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int c_V_TOTAL = c_V_BLANK + V_ACT;

    localparam logic [CW-1:0] c_H_BLANK_N  = CW'(c_H_BLANK);
    localparam logic [CW-1:0] c_V_BLANK_N  = CW'(c_V_BLANK);
    localparam logic [CW-1:0] c_H_LAST     = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST     = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_HS_START   = CW'(H_FRONT);
    localparam logic [CW-1:0] c_HS_END     = CW'(H_FRONT + H_SYNC);
    localparam logic [CW-1:0] c_VS_START   = CW'(V_FRONT);
    localparam logic [CW-1:0] c_VS_END     = CW'(V_FRONT + V_SYNC);
    localparam logic [CW-1:0] c_PREFETCH_N = CW'(PREFETCH);
    localparam logic [CW:0]   c_H_BLANK_W  = (CW+1)'(c_H_BLANK);
    localparam logic [CW:0]   c_H_TOTAL_W  = (CW+1)'(c_H_TOTAL);
    localparam logic [CW:0]   c_PREFETCH_W = (CW+1)'(PREFETCH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_STOP = 2'd2;

    generate
        if (H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0 || H_ACT <= 0 ||
            V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0 || V_ACT <= 0 ||
            PREFETCH < 0 || PREFETCH > c_H_BLANK ||
            c_H_TOTAL >= (2**CW) || c_V_TOTAL >= (2**CW)) begin : g_param_check
            $error("vga_timing_gen: illegal timing parameters");
        end
    endgenerate

    logic [1:0]    r_state;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic [15:0]   r_frame_cnt;

    logic          w_run;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_v_act;
    logic          w_active;
    logic          w_hs_win;
    logic          w_vs_win;
    logic          w_req;
    logic [CW:0]   w_hp;

    assign w_run    = (r_state != c_IDLE);
    assign w_h_last = (r_h == c_H_LAST);
    assign w_v_last = (r_v == c_V_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= c_IDLE;
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_h <= '0;
                    r_v <= '0;
                    if (i_en) r_state <= c_RUN;
                end
                c_RUN, c_STOP: begin
                    if (w_h_last) begin
                        r_h <= '0;
                        r_v <= w_v_last ? '0 : r_v + 1'b1;
                    end else begin
                        r_h <= r_h + 1'b1;
                    end
                    // A stop request only takes effect at the frame boundary.
                    if (w_h_last && w_v_last) begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        if (r_state == c_STOP || !i_en) r_state <= c_IDLE;
                    end else if (!i_en) begin
                        r_state <= c_STOP;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign w_v_act  = (r_v >= c_V_BLANK_N);
    assign w_active = w_run && w_v_act && (r_h >= c_H_BLANK_N);
    assign w_hs_win = w_run && (r_h >= c_HS_START) && (r_h < c_HS_END);
    assign w_vs_win = w_run && (r_v >= c_VS_START) && (r_v < c_VS_END);

    // Look-ahead column, kept one bit wider so it never wraps past the line end.
    assign w_hp  = {1'b0, r_h} + c_PREFETCH_W;
    assign w_req = w_run && w_v_act && (w_hp >= c_H_BLANK_W) && (w_hp < c_H_TOTAL_W);

    assign o_x           = w_active ? (r_h - c_H_BLANK_N) : '0;
    assign o_y           = w_active ? (r_v - c_V_BLANK_N) : '0;
    assign o_blank_n     = w_active;
    assign o_hs          = w_hs_win ? HS_POL : ~HS_POL;
    assign o_vs          = w_vs_win ? VS_POL : ~VS_POL;
    assign o_sync_n      = 1'b0;
    assign o_vga_clk     = ~i_clk;
    assign o_req         = w_req;
    assign o_req_x       = w_req ? (r_h + c_PREFETCH_N - c_H_BLANK_N) : '0;
    assign o_req_y       = w_req ? (r_v - c_V_BLANK_N) : '0;
    assign o_line_start  = w_run && (r_h == '0);
    assign o_frame_start = w_run && (r_h == '0) && (r_v == '0);
    assign o_busy        = w_run;
    assign o_frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Scoreboard bench for vga_timing_gen (reduced raster sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HF = 4, HSW = 6, HBP = 5, HA = 20;
    localparam int VF = 2, VSW = 2, VBP = 3, VA = 8;
    localparam int PF = 2, CW = 11;
    localparam int HBL = HF + HSW + HBP, HT = HBL + HA;
    localparam int VBL = VF + VSW + VBP, VT = VBL + VA;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_en = 1'b0;

    logic [CW-1:0] a_x, a_y, a_rx, a_ry, b_x, b_y, b_rx, b_ry;
    logic a_hs, a_vs, a_blank_n, a_sync_n, a_vga_clk, a_req, a_ls, a_fs, a_busy;
    logic b_hs, b_vs, b_blank_n, b_sync_n, b_vga_clk, b_req, b_ls, b_fs, b_busy;
    logic [15:0] a_fc, b_fc;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP), .H_ACT(HA),
                     .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .V_ACT(VA),
                     .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(PF), .CW(CW)) dut_a (
        .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
        .o_x(a_x), .o_y(a_y), .o_hs(a_hs), .o_vs(a_vs), .o_blank_n(a_blank_n),
        .o_sync_n(a_sync_n), .o_vga_clk(a_vga_clk), .o_req(a_req), .o_req_x(a_rx),
        .o_req_y(a_ry), .o_line_start(a_ls), .o_frame_start(a_fs), .o_busy(a_busy),
        .o_frame_cnt(a_fc));

    vga_timing_gen #(.H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBP), .H_ACT(HA),
                     .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBP), .V_ACT(VA),
                     .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(0), .CW(CW)) dut_b (
        .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
        .o_x(b_x), .o_y(b_y), .o_hs(b_hs), .o_vs(b_vs), .o_blank_n(b_blank_n),
        .o_sync_n(b_sync_n), .o_vga_clk(b_vga_clk), .o_req(b_req), .o_req_x(b_rx),
        .o_req_y(b_ry), .o_line_start(b_ls), .o_frame_start(b_fs), .o_busy(b_busy),
        .o_frame_cnt(b_fc));

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          hs;
        logic          vs;
        logic          blank_n;
        logic          sync_n;
        logic          req;
        logic [CW-1:0] rx;
        logic [CW-1:0] ry;
        logic          ls;
        logic          fs;
        logic          busy;
        logic [15:0]   fc;
    } out_t;

    out_t obs_a, obs_b;
    assign obs_a = {a_x, a_y, a_hs, a_vs, a_blank_n, a_sync_n, a_req, a_rx, a_ry, a_ls, a_fs, a_busy, a_fc};
    assign obs_b = {b_x, b_y, b_hs, b_vs, b_blank_n, b_sync_n, b_req, b_rx, b_ry, b_ls, b_fs, b_busy, b_fc};

    out_t q_a[$];
    out_t q_b[$];
    int checks = 0;
    int errors = 0;

    // Reference position/state: 0 idle, 1 run, 2 stop
    int mst = 0, mh = 0, mv = 0, mfc = 0;

    int n_blank, n_hs, n_vs, n_req, n_req_early, n_bhs;
    int fa_h, fa_v, fa_x, fa_y, la_x, la_y;
    int fr_h, fr_rx, lr_h, lr_rx;

    function automatic out_t model_out(input bit hpol, input bit vpol, input int pf);
        out_t o;
        int   hp;
        o    = '0;
        o.hs = ~hpol;
        o.vs = ~vpol;
        o.fc = mfc[15:0];
        if (mst != 0) begin
            o.busy = 1'b1;
            if (mh >= HBL && mv >= VBL) begin
                o.blank_n = 1'b1;
                o.x = CW'(mh - HBL);
                o.y = CW'(mv - VBL);
            end
            if (mh >= HF && mh < HF + HSW) o.hs = hpol;
            if (mv >= VF && mv < VF + VSW) o.vs = vpol;
            hp = mh + pf;
            if (mv >= VBL && hp >= HBL && hp < HT) begin
                o.req = 1'b1;
                o.rx  = CW'(hp - HBL);
                o.ry  = CW'(mv - VBL);
            end
            o.ls = (mh == 0);
            o.fs = (mh == 0) && (mv == 0);
        end
        return o;
    endfunction

    task automatic model_edge(input bit rst, input bit en);
        bit last;
        if (rst) begin
            mst = 0; mh = 0; mv = 0; mfc = 0;
        end else if (mst == 0) begin
            mh = 0; mv = 0;
            if (en) mst = 1;
        end else begin
            last = (mh == HT - 1) && (mv == VT - 1);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (last) begin
                mfc = (mfc + 1) % 65536;
                if (mst == 2 || !en) mst = 0;
            end else if (!en) begin
                mst = 2;
            end
        end
    endtask

    task automatic clear_counters();
        n_blank = 0; n_hs = 0; n_vs = 0; n_req = 0; n_req_early = 0; n_bhs = 0;
        fa_h = -1; fa_v = -1; fa_x = -1; fa_y = -1; la_x = -1; la_y = -1;
        fr_h = -1; fr_rx = -1; lr_h = -1; lr_rx = -1;
    endtask

    task automatic step(input bit rst, input bit en);
        out_t ea, eb;
        i_reset = rst;
        i_en    = en;
        model_edge(rst, en);
        q_a.push_back(model_out(1'b0, 1'b0, PF));
        q_b.push_back(model_out(1'b1, 1'b1, 0));
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        checks++;
        if (obs_a !== ea) begin
            errors++;
            $display("FAIL sb_a h=%0d v=%0d got=%h exp=%h", mh, mv, obs_a, ea);
        end
        checks++;
        if (obs_b !== eb) begin
            errors++;
            $display("FAIL sb_b h=%0d v=%0d got=%h exp=%h", mh, mv, obs_b, eb);
        end
        if (a_blank_n) begin
            if (n_blank == 0) begin fa_h = mh; fa_v = mv; fa_x = int'(a_x); fa_y = int'(a_y); end
            la_x = int'(a_x); la_y = int'(a_y);
            n_blank++;
        end
        if (a_req) begin
            if (n_req == 0) begin fr_h = mh; fr_rx = int'(a_rx); end
            lr_h = mh; lr_rx = int'(a_rx);
            n_req++;
            if (mv < VBL) n_req_early++;
        end
        if (!a_hs) n_hs++;
        if (!a_vs) n_vs++;
        if (b_hs) n_bhs++;
    endtask

    task automatic test_reset();
        repeat (3) step(1'b1, 1'b0);
        checks++;
        if ({a_busy, a_hs, a_vs, b_hs, b_vs, a_sync_n, a_blank_n, a_req} !== 8'b0110_0000) begin
            errors++;
            $display("FAIL reset_levels got=%b exp=01100000",
                     {a_busy, a_hs, a_vs, b_hs, b_vs, a_sync_n, a_blank_n, a_req});
        end
        checks++;
        if (a_vga_clk !== ~clk) begin
            errors++;
            $display("FAIL vga_clk got=%b exp=%b", a_vga_clk, ~clk);
        end
        checks++;
        if (a_fc !== 16'd0) begin
            errors++;
            $display("FAIL reset_fc got=%0d exp=0", a_fc);
        end
    endtask

    task automatic test_start_hsync();
        int first;
        int cnt;
        step(1'b0, 1'b1);
        checks++;
        if ({a_busy, a_fs, a_ls} !== 3'b111) begin
            errors++;
            $display("FAIL start_pulse got=%b exp=111", {a_busy, a_fs, a_ls});
        end
        first = -1;
        cnt   = 0;
        for (int i = 1; i < HT; i++) begin
            step(1'b0, 1'b1);
            if (!a_hs) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        checks++;
        if (first != HF || cnt != HSW) begin
            errors++;
            $display("FAIL hsync_window got first=%0d len=%0d exp first=%0d len=%0d", first, cnt, HF, HSW);
        end
    endtask

    task automatic test_frame();
        step(1'b1, 1'b0);
        clear_counters();
        for (int i = 0; i < HT * VT; i++) step(1'b0, 1'b1);
        checks++;
        if (n_blank != HA * VA) begin
            errors++;
            $display("FAIL blank_count got=%0d exp=%0d", n_blank, HA * VA);
        end
        checks++;
        if (fa_h != HBL || fa_v != VBL || fa_x != 0 || fa_y != 0 || la_x != HA - 1 || la_y != VA - 1) begin
            errors++;
            $display("FAIL active_bounds got h=%0d v=%0d x=%0d y=%0d last=%0d,%0d exp %0d %0d 0 0 %0d,%0d",
                     fa_h, fa_v, fa_x, fa_y, la_x, la_y, HBL, VBL, HA - 1, VA - 1);
        end
        checks++;
        if (n_hs != HSW * VT || n_vs != VSW * HT || n_bhs != HSW * VT) begin
            errors++;
            $display("FAIL sync_counts got hs=%0d vs=%0d bhs=%0d exp %0d %0d %0d",
                     n_hs, n_vs, n_bhs, HSW * VT, VSW * HT, HSW * VT);
        end
        checks++;
        if (n_req != HA * VA || n_req_early != 0) begin
            errors++;
            $display("FAIL req_count got=%0d early=%0d exp=%0d early=0", n_req, n_req_early, HA * VA);
        end
        checks++;
        if (fr_h != HBL - PF || fr_rx != 0 || lr_h != HT - 1 - PF || lr_rx != HA - 1) begin
            errors++;
            $display("FAIL req_bounds got first h=%0d x=%0d last h=%0d x=%0d exp %0d 0 %0d %0d",
                     fr_h, fr_rx, lr_h, lr_rx, HBL - PF, HT - 1 - PF, HA - 1);
        end
        step(1'b0, 1'b1);
        checks++;
        if (a_fc !== 16'd1 || a_fs !== 1'b1) begin
            errors++;
            $display("FAIL frame_cnt1 got fc=%0d fs=%b exp fc=1 fs=1", a_fc, a_fs);
        end
        for (int i = 1; i < HT * VT; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (a_fc !== 16'd2 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back got fc=%0d busy=%b exp fc=2 busy=1", a_fc, a_busy);
        end
    endtask

    task automatic test_stop();
        bit done;
        int px, py;
        bit pb;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < HT * VT && mv != 10; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_early got busy=%b exp=1", a_busy);
        end
        repeat (5) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        done = 1'b0;
        px = -1; py = -1; pb = 1'b0;
        for (int i = 0; i < 2 * HT * VT && !done; i++) begin
            px = int'(a_x); py = int'(a_y); pb = a_blank_n;
            step(1'b0, 1'b0);
            if (a_busy === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done || px != HA - 1 || py != VA - 1 || pb != 1'b1) begin
            errors++;
            $display("FAIL stop_frame_end got done=%b last x=%0d y=%0d blank=%b exp 1 %0d %0d 1",
                     done, px, py, pb, HA - 1, VA - 1);
        end
        checks++;
        if (a_fc !== 16'd1 || a_hs !== 1'b1 || a_vs !== 1'b1) begin
            errors++;
            $display("FAIL stop_idle got fc=%0d hs=%b vs=%b exp 1 1 1", a_fc, a_hs, a_vs);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3 * HT * VT && !(mfc == 1 && mv == 10 && mh == 20); i++) step(1'b0, 1'b1);
        checks++;
        if (a_fc !== 16'd1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup got fc=%0d busy=%b exp 1 1", a_fc, a_busy);
        end
        step(1'b1, 1'b1);
        checks++;
        if ({a_x, a_y, a_rx, a_ry} !== '0 || {a_blank_n, a_req, a_ls, a_fs, a_busy, a_sync_n} !== 6'b0 ||
            a_hs !== 1'b1 || a_vs !== 1'b1 || a_fc !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got=%h exp x,y,req=0 hs=vs=1 fc=0", obs_a);
        end
        step(1'b0, 1'b1);
        checks++;
        if ({a_busy, a_fs, a_ls} !== 3'b111 || a_x !== '0 || a_y !== '0) begin
            errors++;
            $display("FAIL mid_restart got busy,fs,ls=%b x=%0d y=%0d exp 111 0 0", {a_busy, a_fs, a_ls}, a_x, a_y);
        end
    endtask

    task automatic test_idle_hold();
        out_t snap_a, snap_b;
        int toggles;
        step(1'b1, 1'b0);
        snap_a  = obs_a;
        snap_b  = obs_b;
        toggles = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 1'b0);
            if (obs_a !== snap_a || obs_b !== snap_b) toggles++;
        end
        checks++;
        if (toggles != 0) begin
            errors++;
            $display("FAIL idle_toggles got=%0d exp=0", toggles);
        end
        checks++;
        if ({b_hs, b_vs, a_hs, a_vs} !== 4'b0011) begin
            errors++;
            $display("FAIL idle_polarity got=%b exp=0011", {b_hs, b_vs, a_hs, a_vs});
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_start_hsync();
        test_frame();
        test_stop();
        test_reset_mid();
        test_idle_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  H_FRONT 16 horizontal front porch cycles; H_SYNC 96 hsync cycles; H_BACK 48 back porch cycles; H_ACT 640 active pixels
  V_FRONT 10, V_SYNC 2, V_BACK 33, V_ACT 480: vertical equivalents, in lines
  HS_POL 0: hsync active level (0 = active-low); VS_POL 0: vsync active level
  PREFETCH 2: pixel-request lead in cycles, range 0..H_FRONT+H_SYNC+H_BACK
  CW 11: coordinate/counter width
REQ-002 SHALL have ports, one per line (name direction width meaning), clock and reset first:
  i_clk in 1 pixel clock; i_reset in 1 reset
  i_en in 1 run request
  o_x out CW active column; o_y out CW active row
  o_hs out 1 hsync; o_vs out 1 vsync
  o_blank_n out 1 high in active region; o_sync_n out 1 constant 0; o_vga_clk out 1 ~i_clk
  o_req out 1 pixel fetch request; o_req_x out CW, o_req_y out CW: fetch coordinates
  o_line_start out 1 pulse; o_frame_start out 1 pulse; o_busy out 1 not idle; o_frame_cnt out 16 completed frames
REQ-003 SHALL use one clock; reset is synchronous and active-high (i_clk, i_reset).
REQ-004 SHALL fail elaboration if PREFETCH exceeds H_BLANK or any timing parameter is 0.

Function
REQ-005 Definitions: H_BLANK=H_FRONT+H_SYNC+H_BACK, H_TOTAL=H_BLANK+H_ACT; V_BLANK, V_TOTAL likewise.
REQ-006 Position (h,v) SHALL be held in registers; h order per line: front, sync, back, active; v order per frame: front, sync, back, active.
REQ-007 States IDLE, RUN, STOP. IDLE: position held (0,0). IDLE with i_en=1 -> RUN next cycle at (0,0).
REQ-008 RUN/STOP: h increments each cycle; h=H_TOTAL-1 -> h=0, v+1; (H_TOTAL-1,V_TOTAL-1) -> (0,0).
REQ-009 RUN with i_en=0 -> STOP (sticky; i_en re-assertion ignored); STOP completes the frame, and after cycle at (H_TOTAL-1,V_TOTAL-1) -> IDLE; no partial frames.
REQ-010 All outputs in a cycle SHALL be functions of the position and state registers of that cycle; no combinational path from i_en.
REQ-011 Active: h>=H_BLANK and v>=V_BLANK, state!=IDLE; o_blank_n=active; o_x=h-H_BLANK, o_y=v-V_BLANK when active, else 0.
REQ-012 o_hs=HS_POL when state!=IDLE and H_FRONT<=h<H_FRONT+H_SYNC, else ~HS_POL; o_vs=VS_POL when state!=IDLE and V_FRONT<=v<V_FRONT+V_SYNC (whole lines), else ~VS_POL.
REQ-013 o_req=1 in cycle with position (h,v) iff (h+PREFETCH,v) is active; o_req_x=h+PREFETCH-H_BLANK, o_req_y=v-V_BLANK; else both 0. Requests never cross a line boundary; PREFETCH=0 makes o_req equal o_blank_n.
REQ-014 o_line_start=1 at h=0 (state!=IDLE); o_frame_start=1 at (0,0) (state!=IDLE); each one cycle.
REQ-015 o_busy=1 in RUN and STOP.
REQ-016 o_frame_cnt SHALL increment (wrapping at 2^16) on each cycle at (H_TOTAL-1,V_TOTAL-1) in RUN or STOP.

Reset
REQ-017 i_reset=1 at a clock edge SHALL force IDLE, position (0,0), o_frame_cnt=0, regardless of state, including mid-frame.
REQ-018 Reset values: o_x=o_y=o_req_x=o_req_y=0; o_blank_n=o_req=o_line_start=o_frame_start=o_busy=0; o_hs=~HS_POL; o_vs=~VS_POL; o_sync_n=0.

Verification (defaults: H_TOTAL=800, H_BLANK=160, V_TOTAL=525, V_BLANK=45)
REQ-019 Reset, i_en=1 -> next cycle o_busy=1, o_frame_start=1; o_hs low for exactly 96 cycles starting 16 cycles later; o_vs low for lines 10-11 (1600 cycles).
REQ-020 Run one frame -> o_blank_n high exactly 307200 cycles; first active cycle o_x=0,o_y=0 at h=160,v=45; last o_x=639,o_y=479; o_frame_cnt=1 after 420000 cycles.
REQ-021 PREFETCH=2 -> o_req first high at h=158 with o_req_x=0; last at h=797 with o_req_x=639; 640 requests per active line, none in v<45.
REQ-022 Drop i_en mid-frame (v=200) -> frame completes to (799,524), o_busy falls the next cycle, hs/vs inactive; pulse i_en back during STOP -> no effect.
REQ-023 Assert i_reset at v=300,h=400 -> next cycle all outputs at REQ-018 values; with i_en=1 restart at (0,0).
REQ-024 HS_POL=1,VS_POL=1 -> sync pulses active-high, idle-high polarity inverted accordingly; IDLE with i_en=0 held 1000 cycles -> no toggles.
